// File: rtl/xgmii_probe_rx.sv
// xgmii_probe_rx: XGMII RX probe-frame checker publishing latency, per-second rate and last destination IP.
module xgmii_probe_rx #(
    parameter logic [39:0] MAGIC_CODE = 40'h50524f4245,
    parameter logic [15:0] UDP_PORT   = 16'h0d5e
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        sec_oneshot,
    input  logic [31:0] global_counter,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    output logic [31:0] rx_pps,
    output logic [31:0] rx_throughput,
    output logic [23:0] rx_latency,
    output logic [23:0] rx_latency_max,
    output logic [31:0] rx_ipv4_ip,
    output logic [31:0] rx_err_count
);
    localparam logic [1:0] IDLE = 2'd0, HDR = 2'd1, BODY = 2'd2, DROP = 2'd3;
    localparam logic [63:0] START_WORD = 64'hd5555555555555fb;
    localparam logic [63:0] IDLE_WORD  = 64'h0707070707070707;

    logic [1:0]  state_q, state_d;
    logic [15:0] w_q, w_d;
    logic        match_q, match_d;
    logic [31:0] ip_q, ip_d;
    logic [7:0]  ts_hi_q, ts_hi_d;
    logic [23:0] lat_q, lat_d;
    logic [31:0] pps_acc_q, byte_acc_q;
    logic [23:0] lat_max_acc_q;

    logic [7:0]  ln [8];
    logic        is_start, all_idle, term_ok, mis, err, good;
    logic [2:0]  term_k;
    logic [31:0] lat32, frame_bytes, pps_nx, byte_nx;
    logic [32:0] byte_sum;
    logic [23:0] lat_sat, max_nx;

    genvar g;
    for (g = 0; g < 8; g++) begin : g_lane
        assign ln[g] = xgmii_rxd[8*g +: 8];
    end

    assign is_start = xgmii_rxc == 8'h01 && xgmii_rxd == START_WORD;
    assign all_idle = xgmii_rxc == 8'hff && xgmii_rxd == IDLE_WORD;

    // Terminate lane is the lowest control lane; every lane from there up must be control.
    always_comb begin
        term_k = 3'd0;
        for (int k = 7; k >= 0; k--)
            if (xgmii_rxc[k]) term_k = 3'(k);
    end
    assign term_ok = xgmii_rxc != 8'h00 && ln[term_k] == 8'hfd &&
                     (xgmii_rxc >> term_k) == (8'hff >> term_k);

    assign mis = (w_q == 16'd2 && {ln[4], ln[5], ln[6]} != 24'h080045) ||
                 (w_q == 16'd3 && ln[7] != 8'h11) ||
                 (w_q == 16'd5 && {ln[4], ln[5]} != UDP_PORT) ||
                 (w_q == 16'd6 && {ln[2], ln[3], ln[4], ln[5], ln[6]} != MAGIC_CODE);

    assign lat32       = global_counter - {ts_hi_q, ln[0], ln[1], ln[2]};
    assign lat_sat     = (|lat32[31:24]) ? 24'hffffff : lat32[23:0];
    assign frame_bytes = {13'd0, w_q - 16'd1, term_k};

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        match_d = match_q;
        ip_d    = ip_q;
        ts_hi_d = ts_hi_q;
        lat_d   = lat_q;
        err     = 1'b0;
        good    = 1'b0;
        case (state_q)
            IDLE: if (is_start) begin
                state_d = HDR;
                w_d     = 16'd1;
                match_d = 1'b1;
            end
            DROP: if (all_idle) state_d = IDLE;
            default: if (is_start) begin
                err     = 1'b1;
                state_d = HDR;
                w_d     = 16'd1;
                match_d = 1'b1;
            end else if (xgmii_rxc != 8'h00) begin
                err     = !term_ok;
                good    = term_ok && w_q >= 16'd8 && match_q;
                state_d = term_ok ? IDLE : DROP;
            end else begin
                w_d = (w_q == 16'hffff) ? w_q : w_q + 16'd1;
                if (state_q == HDR) begin
                    match_d = match_q && !mis;
                    if (w_q == 16'd4) ip_d[31:16] = {ln[6], ln[7]};
                    if (w_q == 16'd5) ip_d[15:0] = {ln[0], ln[1]};
                    if (w_q == 16'd6) ts_hi_d = ln[7];
                    if (w_q == 16'd7) begin
                        lat_d   = lat_sat;
                        state_d = BODY;
                    end
                end
            end
        endcase
    end

    assign byte_sum = {1'b0, byte_acc_q} + {1'b0, frame_bytes};
    assign pps_nx   = (good && pps_acc_q != 32'hffffffff) ? pps_acc_q + 32'd1 : pps_acc_q;
    assign byte_nx  = !good ? byte_acc_q : byte_sum[32] ? 32'hffffffff : byte_sum[31:0];
    assign max_nx   = (good && lat_q > lat_max_acc_q) ? lat_q : lat_max_acc_q;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q        <= IDLE;
            w_q            <= 16'd0;
            match_q        <= 1'b0;
            ip_q           <= 32'd0;
            ts_hi_q        <= 8'd0;
            lat_q          <= 24'd0;
            pps_acc_q      <= 32'd0;
            byte_acc_q     <= 32'd0;
            lat_max_acc_q  <= 24'd0;
            rx_pps         <= 32'd0;
            rx_throughput  <= 32'd0;
            rx_latency     <= 24'd0;
            rx_latency_max <= 24'd0;
            rx_ipv4_ip     <= 32'd0;
            rx_err_count   <= 32'd0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            match_q <= match_d;
            ip_q    <= ip_d;
            ts_hi_q <= ts_hi_d;
            lat_q   <= lat_d;
            if (err && rx_err_count != 32'hffffffff) rx_err_count <= rx_err_count + 32'd1;
            if (good) begin
                rx_latency <= lat_q;
                rx_ipv4_ip <= ip_q;
            end
            // A frame finishing on the second boundary lands in the closing second.
            if (sec_oneshot) begin
                rx_pps         <= pps_nx;
                rx_throughput  <= byte_nx;
                rx_latency_max <= max_nx;
                pps_acc_q      <= 32'd0;
                byte_acc_q     <= 32'd0;
                lat_max_acc_q  <= 24'd0;
            end else begin
                pps_acc_q     <= pps_nx;
                byte_acc_q    <= byte_nx;
                lat_max_acc_q <= max_nx;
            end
        end
    end
endmodule

// File: tb/tb_xgmii_probe_rx.sv
// tb_xgmii_probe_rx: table-driven and scoreboard checks of xgmii_probe_rx.
module tb_xgmii_probe_rx;
    localparam logic [39:0] MAGIC = 40'h50524f4245;
    localparam logic [63:0] START = 64'hd5555555555555fb;
    localparam logic [63:0] IDLEW = 64'h0707070707070707;

    logic        sys_clk = 1'b0, sys_rst = 1'b0, sec_oneshot = 1'b0;
    logic [31:0] global_counter = 32'd0;
    logic [63:0] xgmii_rxd = IDLEW;
    logic [7:0]  xgmii_rxc = 8'hff;
    logic [31:0] rx_pps, rx_throughput, rx_ipv4_ip, rx_err_count;
    logic [23:0] rx_latency, rx_latency_max;

    xgmii_probe_rx #(.MAGIC_CODE(MAGIC), .UDP_PORT(16'h0d5e)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sec_oneshot(sec_oneshot),
        .global_counter(global_counter), .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc),
        .rx_pps(rx_pps), .rx_throughput(rx_throughput), .rx_latency(rx_latency),
        .rx_latency_max(rx_latency_max), .rx_ipv4_ip(rx_ipv4_ip), .rx_err_count(rx_err_count)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] ts, gc, ip;
        logic        bad_magic, good;
        logic [23:0] lat;
    } vec_t;
    typedef struct {
        logic [23:0] lat;
        logic [31:0] ip;
    } exp_t;

    vec_t        vecs [5];
    exp_t        sb [$];
    int          errors = 0, checks = 0;
    logic [7:0]  fb [68];
    logic [23:0] m_lat = 24'd0, e_max = 24'd0;
    logic [31:0] m_ip = 32'd0, m_err = 32'd0, e_pps = 32'd0, e_bytes = 32'd0;

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build(input logic [31:0] ts, input logic [31:0] ip, input logic bad);
        for (int i = 0; i < 68; i++) fb[i] = 8'(i * 3 + 1);
        {fb[12], fb[13], fb[14]} = 24'h080045;
        fb[23] = 8'h11;
        {fb[30], fb[31], fb[32], fb[33]} = ip;
        {fb[36], fb[37]} = 16'h0d5e;
        {fb[42], fb[43], fb[44], fb[45], fb[46]} = MAGIC;
        {fb[47], fb[48], fb[49], fb[50]} = ts;
        if (bad) fb[44] = ~fb[44];
    endtask

    function automatic logic [63:0] dword(input int w);
        logic [63:0] r;
        for (int j = 0; j < 8; j++) r[8*j +: 8] = fb[8*(w-1) + j];
        return r;
    endfunction

    task automatic drive(input logic [63:0] d, input logic [7:0] c);
        xgmii_rxd = d;
        xgmii_rxc = c;
        tick();
    endtask

    task automatic head(input vec_t v, input int n);
        build(v.ts, v.ip, v.bad_magic);
        global_counter = v.gc;
        drive(START, 8'h01);
        for (int w = 1; w <= n; w++) drive(dword(w), 8'h00);
    endtask

    task automatic term(input logic os);
        sec_oneshot = os;
        drive({24'h070707, 8'hfd, fb[67], fb[66], fb[65], fb[64]}, 8'hf0);
        sec_oneshot = 1'b0;
    endtask

    task automatic check_second;
        chk("rx_pps", rx_pps, e_pps);
        chk("rx_throughput", rx_throughput, e_bytes);
        chk("rx_latency_max", rx_latency_max, e_max);
        e_pps = 0;
        e_bytes = 0;
        e_max = 0;
    endtask

    task automatic second;
        sec_oneshot = 1'b1;
        drive(IDLEW, 8'hff);
        sec_oneshot = 1'b0;
        check_second();
    endtask

    task automatic frame(input vec_t v, input logic os);
        exp_t e;
        head(v, 8);
        if (v.good) begin
            m_lat = v.lat;
            m_ip = v.ip;
            e_pps++;
            e_bytes += 32'd68;
            if (v.lat > e_max) e_max = v.lat;
        end
        sb.push_back('{m_lat, m_ip});
        term(os);
        e = sb.pop_front();
        chk("rx_latency", rx_latency, e.lat);
        chk("rx_ipv4_ip", rx_ipv4_ip, e.ip);
        chk("rx_err_count", rx_err_count, m_err);
        if (os) check_second();
        drive(IDLEW, 8'hff);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " pps"}, rx_pps, 0);
        chk({tag, " thr"}, rx_throughput, 0);
        chk({tag, " lat"}, rx_latency, 0);
        chk({tag, " latmax"}, rx_latency_max, 0);
        chk({tag, " ip"}, rx_ipv4_ip, 0);
        chk({tag, " err"}, rx_err_count, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not end, limit 5000000 expected earlier");
        $fatal(1);
    end

    initial begin
        vec_t        v;
        logic [63:0] t;
        vecs[0] = '{32'h00000100, 32'h00000164, 32'hc0a80101, 1'b0, 1'b1, 24'h000064};
        vecs[1] = '{32'h00000000, 32'h01000005, 32'h0a000001, 1'b0, 1'b1, 24'hffffff};
        vecs[2] = '{32'hfffffff0, 32'h00000010, 32'h0a000002, 1'b0, 1'b1, 24'h000020};
        vecs[3] = '{32'h00000100, 32'h00000200, 32'h0b000003, 1'b1, 1'b0, 24'h000100};
        vecs[4] = '{32'h12345678, 32'h12345778, 32'hac100004, 1'b0, 1'b1, 24'h000100};
        repeat (3) tick();
        check_zero("reset");
        sys_rst = 1'b1;
        tick();
        foreach (vecs[i]) frame(vecs[i], 1'b0);
        second();
        second();
        head(vecs[0], 4);
        t = dword(5);
        t[39:32] = 8'hfe;
        drive(t, 8'h10);
        m_err++;
        drive(dword(6), 8'h00);
        drive(dword(7), 8'h00);
        term(1'b0);
        chk("abort err", rx_err_count, m_err);
        chk("abort lat", rx_latency, m_lat);
        drive(IDLEW, 8'hff);
        frame(vecs[4], 1'b1);
        second();
        for (int i = 0; i < 1000; i++) begin
            v.lat = 24'((i * 37) % 5000);
            v.ts = 32'h1000 + 32'(i);
            v.gc = v.ts + {8'd0, v.lat};
            v.ip = 32'h0a000000 + 32'(i);
            v.bad_magic = 1'b0;
            v.good = 1'b1;
            frame(v, 1'b0);
        end
        second();
        second();
        head(vecs[0], 4);
        sys_rst = 1'b0;
        #1;
        check_zero("midreset");
        m_lat = 0;
        m_ip = 0;
        m_err = 0;
        e_pps = 0;
        e_bytes = 0;
        e_max = 0;
        drive(dword(5), 8'h00);
        drive(IDLEW, 8'hff);
        sys_rst = 1'b1;
        drive(IDLEW, 8'hff);
        frame(vecs[0], 1'b0);
        second();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
